// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU requesters and alu_share_arbiter.
// Requesters use the master modport; the arbiter uses the slave modport.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [3:0]       req0_control;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [3:0]       req1_control;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_out;
  logic             rsp_zero;
  logic             rsp_overflow;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_a, req0_b, req0_control,
    output req1_valid, req1_a, req1_b, req1_control,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_out, rsp_zero, rsp_overflow, rsp_err
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_control,
    input  req1_valid, req1_a, req1_b, req1_control,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_out, rsp_zero, rsp_overflow, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between the EX issue path (req0) and the
// branch/address-compare unit (req1); one operation in flight at a time.
module alu_share_arbiter #(
  parameter int          WIDTH        = 32,
  parameter int          ALU_LATENCY  = 1,
  parameter logic [3:0]  ALU_ERR_CODE = 4'b1111
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_arbiter_if.slave bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_overflow
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] LAT = 3'(ALU_LATENCY);

  state_t           state;
  logic             prio;      // 0: req0 wins a tie, 1: req1 wins a tie
  logic             id;        // requester currently being served
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       ctrl_q;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] out_q;
  logic             zero_q;
  logic             ovf_q;
  logic             err_q;

  logic             idle;
  logic             grant1;
  logic             req_hs;
  logic             rsp_hs;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       sel_ctrl;

  // Grant is combinational so a lone requester is accepted in its first valid cycle.
  assign idle           = (state == IDLE) && !rst;
  assign grant1         = bus.req1_valid && (!bus.req0_valid || prio);
  assign bus.req0_ready = idle && bus.req0_valid && !grant1;
  assign bus.req1_ready = idle && grant1;
  assign req_hs         = bus.req0_ready || bus.req1_ready;

  assign sel_a    = grant1 ? bus.req1_a       : bus.req0_a;
  assign sel_b    = grant1 ? bus.req1_b       : bus.req0_b;
  assign sel_ctrl = grant1 ? bus.req1_control : bus.req0_control;

  assign bus.rsp0_valid   = (state == RESP) && !id;
  assign bus.rsp1_valid   = (state == RESP) && id;
  assign bus.rsp_out      = out_q;
  assign bus.rsp_zero     = zero_q;
  assign bus.rsp_overflow = ovf_q;
  assign bus.rsp_err      = err_q;
  assign rsp_hs           = id ? (bus.rsp1_valid && bus.rsp1_ready)
                               : (bus.rsp0_valid && bus.rsp0_ready);

  // ALU inputs are quiet outside EXEC so the shared ALU sees no stray activity.
  assign alu_a       = (state == EXEC) ? a_q    : '0;
  assign alu_b       = (state == EXEC) ? b_q    : '0;
  assign alu_control = (state == EXEC) ? ctrl_q : 4'b0000;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      prio   <= 1'b0;
      id     <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= 4'b0000;
      cnt    <= 3'd0;
      out_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_hs) begin
            id     <= grant1;
            a_q    <= sel_a;
            b_q    <= sel_b;
            ctrl_q <= sel_ctrl;
            cnt    <= 3'd0;
            if (sel_ctrl == ALU_ERR_CODE) begin
              out_q  <= '0;
              zero_q <= 1'b0;
              ovf_q  <= 1'b0;
              err_q  <= 1'b1;
              state  <= RESP;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt == LAT) begin
            out_q  <= alu_out;
            zero_q <= alu_zero;
            ovf_q  <= alu_overflow;
            err_q  <= 1'b0;
            state  <= RESP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            prio  <= ~id;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
